coffee_panel_input: RTL
=======================

# coffee_panel_input

Front-panel input conditioner that sits directly upstream of the `coffee` FSM and drives its `on` and `gen` inputs. It synchronizes and debounces two raw push-buttons (power, brew) and turns power presses into a toggled `on` level. Brew presses become single-cycle `gen` pulses, gated by `on` and by a post-brew lockout window, so the FSM never sees bounce, metastable levels or repeated requests.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive cycles a synchronized level must differ from the debounced level before it is accepted (board build: 500000); must be ≥1.
- `LOCKOUT_CYCLES`, 8: cycles after a `gen` pulse during which further brew presses are ignored; must be ≥1.
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `btn_power`  in  1  raw power button, asynchronous, active-high.
- `btn_brew`  in  1  raw brew button, asynchronous, active-high.
- `on`  out  1  registered power level, feeds `coffee.on`.
- `gen`  out  1  registered one-cycle brew request, feeds `coffee.gen`.
- `lockout`  out  1  high while the brew lockout counter is non-zero.

## Operation
- Per button: 2-flop synchronizer (`s1`→`s2`, reset 0), then debouncer holding `stable` (reset 0) and a counter of width clog2(DEBOUNCE_CYCLES+1).
  - Counter clears on any edge where `s2 == stable`.
  - Counter increments on each edge where `s2 != stable`. On the edge where it would reach DEBOUNCE_CYCLES, `stable` takes `s2` and the counter clears.
  - Press event = `stable & ~stable_q`, combinational, high for exactly 1 cycle. Releases generate no event.
- Power event: toggles `on`. On the edge where `on` goes 1→0, the lockout counter clears and `gen` is 0.
- Brew event: accepted only if `on==1`, `lockout==0` and there is no power event in the same cycle. If accepted:
  - `gen`=1 on the next edge, for exactly one cycle.
  - The lockout counter loads LOCKOUT_CYCLES on that same edge.
- Rejected brew events are dropped, not queued.
- Lockout counter (width clog2(LOCKOUT_CYCLES+1)): decrements by 1 per edge while non-zero and saturates at 0. `lockout = (cnt != 0)`.
- Simultaneous power and brew events: power wins. `on` toggles, brew is dropped, `gen`=0.
- Reset values: `on`=0, `gen`=0, `lockout`=0; synchronizers, `stable`, `stable_q` and all counters 0.
- Reset asserted mid-operation: all outputs drop immediately (asynchronous). A button held through reset release registers as a new press after the normal latency.

## Timing
- Raw rising edge first captured into `s1` at edge k:
  - `s2`=1 after k+1.
  - `stable`=1 after k+1+DEBOUNCE_CYCLES.
  - `on` toggles / `gen` rises after k+2+DEBOUNCE_CYCLES. Total latency DEBOUNCE_CYCLES+3 edges inclusive of k.
- Any `s2` pulse shorter than DEBOUNCE_CYCLES cycles is filtered completely.
- `lockout` is high in the same cycle as `gen` and stays high for exactly LOCKOUT_CYCLES cycles.
- Earliest accepted follow-up brew event is in the first cycle with `lockout`=0. Its `gen` appears one edge later.
- Outputs are registered with no combinational path from input to output. With a 50 ns clock period, a minimum debounced press costs 7 cycles = 350 ns at the default parameters.

## Structure
- Shared package `coffee_pkg`: default constants `DEBOUNCE_CYCLES_DEF`, `LOCKOUT_CYCLES_DEF`. The `coffee` FSM state encoding belongs there too, so this block and the FSM agree.
- Sub-module `btn_debounce`, instantiated twice. It contains the synchronizer, debounce counter and edge detect, and exposes `stable` and `press`.
- Top level holds the `on` toggle, brew acceptance logic, `gen` register and lockout counter.

## Test plan
- Reset: `btn_power`=`btn_brew`=1 while `reset`=1 → `on`=`gen`=`lockout`=0 throughout. Release reset with both buttons held → exactly one power event. `on`=1 after DEBOUNCE_CYCLES+3 edges, brew dropped (power wins).
- Power toggle: `btn_power` high 10 cycles then low, repeated → `on` goes 1 after edge k+6 (default parameters), then 0 on the second press. No `gen` pulses.
- Bounce: `on`=1, `btn_brew` alternating 1/0 every cycle for 6 cycles, then steady high for 10 cycles → exactly one `gen` pulse, 1 cycle wide. `lockout` is high for 8 cycles starting that cycle.
- Gating:
  - Brew press with `on`=0 → no `gen`.
  - Second brew press debounced during lockout → no `gen`.
  - Third press after `lockout` falls → `gen` pulse.
- Simultaneous: `on`=1, both buttons rising on the same edge and held → `on`=0, `gen` stays 0, `lockout` stays 0.
- Reset mid-lockout: assert `reset` 3 cycles after `gen` → `on`, `gen`, `lockout` are 0 in that cycle. After release with buttons idle → all outputs stay 0.

Source files
------------

// File: rtl/coffee_pkg.sv
// Constants and state encoding shared between the front-panel conditioner
// and the coffee FSM it feeds.
package coffee_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned LOCKOUT_CYCLES_DEF  = 8;

  typedef enum logic [1:0] {
    COFFEE_OFF  = 2'd0,
    COFFEE_IDLE = 2'd1,
    COFFEE_BREW = 2'd2,
    COFFEE_DONE = 2'd3
  } coffee_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One push-button path: 2-flop synchronizer, debounce counter and
// rising-edge detect on the debounced level.
module btn_debounce
  import coffee_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic stable,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          stable_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= btn;
      s2       <= s1;
      stable_q <= stable;
      // Accept on the edge the count would reach DEBOUNCE_CYCLES.
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = stable & ~stable_q;

endmodule

// File: rtl/coffee_panel_input.sv
// Front-panel conditioner: debounced power toggle driving `on`, and
// gated one-cycle brew requests with a post-brew lockout window.
module coffee_panel_input
  import coffee_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_power,
  input  logic btn_brew,
  output logic on,
  output logic gen,
  output logic lockout
);

  localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);

  logic          power_stable;
  logic          power_press;
  logic          brew_stable;
  logic          brew_press;
  logic          brew_accept;
  logic          unused_stable;
  logic [LW-1:0] lock_cnt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_power (
    .clock  (clock),
    .reset  (reset),
    .btn    (btn_power),
    .stable (power_stable),
    .press  (power_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_brew (
    .clock  (clock),
    .reset  (reset),
    .btn    (btn_brew),
    .stable (brew_stable),
    .press  (brew_press)
  );

  assign unused_stable = power_stable ^ brew_stable;

  // Power wins over a coincident brew press; rejected presses are dropped.
  assign brew_accept = brew_press & on & ~lockout & ~power_press;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      on       <= 1'b0;
      gen      <= 1'b0;
      lock_cnt <= '0;
    end else begin
      on  <= on ^ power_press;
      gen <= brew_accept;
      if (power_press && on) begin
        lock_cnt <= '0;
      end else if (brew_accept) begin
        lock_cnt <= LW'(LOCKOUT_CYCLES);
      end else if (lock_cnt != '0) begin
        lock_cnt <= lock_cnt - 1'b1;
      end
    end
  end

  assign lockout = (lock_cnt != '0);

endmodule
